prog_loader: RTL and testbench
==============================

# prog_loader

Program-memory loader for the nibble microprocessor. Accepts a framed byte stream (header, payload, checksum) over a valid/ready handshake and writes the payload into the 4096×8 program memory that the processor fetches `program_byte` from, starting at address 0. Holds the processor in reset while loading and releases it only after a successful checksum. It sits between the host byte source and the program-memory write port.

## Interface
- `ADDR_W`, 12, program-memory address width; matches `PC`.
- `DATA_W`, 8, program byte width; matches `program_byte`.
- `clock` in 1: single clock; all state updates on its rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `start` in 1: starts a load; sampled only in IDLE, DONE or ERR.
- `in_data` in 8: stream byte.
- `in_valid` in 1: `in_data` is valid.
- `in_ready` out 1: loader accepts a byte this cycle.
- `prog_we` out 1: program-memory write strobe, one cycle per byte.
- `prog_addr` out 12: write address.
- `prog_data` out 8: write data.
- `cpu_hold` out 1: drives the processor reset; high while loading or after an error.
- `busy` out 1: FSM is not in IDLE, DONE or ERR.
- `done` out 1: the last load succeeded.
- `err` out 1: the last load failed (bad magic or checksum).

## Operation
- A byte transfers on a rising edge when both `in_valid` and `in_ready` are 1. `in_ready` is 1 exactly in HDR_LO, HDR_HI, DATA and CSUM, and depends only on state.
- Frame format:
  - HDR_LO byte = LEN[7:0].
  - HDR_HI byte = {4'hA magic, LEN[11:8]}.
  - LEN payload bytes.
  - One checksum byte = sum of payload bytes modulo 256.
- FSM states and transitions:
  - IDLE: `start` → HDR_LO; `cpu_hold` set to 1; sum, count and address cleared.
  - HDR_LO: on transfer, latch LEN low → HDR_HI.
  - HDR_HI: on transfer:
    - upper nibble ≠ 4'hA → ERR.
    - otherwise latch LEN high; LEN = 0 → CSUM; else → DATA.
  - DATA: on each transfer:
    - issue one write at the current address;
    - sum += byte (8-bit wrap);
    - address and count increment;
    - when count reaches LEN → CSUM.
  - CSUM: on transfer:
    - byte = sum → DONE;
    - otherwise → ERR.
  - DONE: `done` = 1, `cpu_hold` = 0. `start` → HDR_LO with `done` cleared and `cpu_hold` set.
  - ERR: `err` = 1, `cpu_hold` = 1. `start` → HDR_LO with `err` cleared.
- Width and arithmetic rules:
  - Maximum LEN = 4095. The address never wraps within a frame.
  - The checksum is 8-bit and overflow is discarded.
- Outputs and boundary cases:
  - `start` is ignored while `busy` = 1.
  - `in_valid` with `in_ready` = 0 is ignored; no byte is consumed.
  - Bytes already written stay in memory on error. There is no rollback.
  - Payload bytes are written even if the checksum later fails.
  - `reset` asserted mid-frame aborts immediately to IDLE. The partial payload remains in memory.

## Timing
- Reset values (asynchronous, `reset` = 0):
  - state IDLE;
  - `in_ready` 0, `prog_we` 0, `prog_addr` 0, `prog_data` 0;
  - `cpu_hold` 0, `busy` 0, `done` 0, `err` 0.
- `prog_we`, `prog_addr` and `prog_data` are registered:
  - A DATA transfer at edge k gives `prog_we` = 1 during cycle k+1, with that byte and its address (0 for the first byte).
  - `prog_we` is 0 in all other cycles.
- Back-to-back transfers give back-to-back write pulses at consecutive addresses.
- `start` seen at edge k: `busy` = 1, `cpu_hold` = 1 and `in_ready` = 1 from cycle k+1.
- Checksum byte accepted at edge k: `done` or `err` = 1 from cycle k+1.
  - On success, `cpu_hold` falls in the same cycle.
  - The last payload write (cycle k) completes before `cpu_hold` falls.
- Minimum frame time with `in_valid` held high: LEN + 3 cycles after `start`.

## Test plan
- Good frame: `start`; bytes 03, A0, 12, 34, 56, 9C → writes 12@0, 34@1, 56@2 on consecutive cycles. `done` = 1, `err` = 0 and `cpu_hold` = 0 one cycle after the checksum byte.
- Bad checksum: same frame with checksum 9D → three writes still occur; `err` = 1, `cpu_hold` = 1, `done` = 0.
- Bad magic: bytes 03, 50 → ERR right after the second byte. No `prog_we` pulse; `in_ready` = 0 afterwards.
- Zero length and stalls: bytes 00, A0, 00 with `in_valid` toggled every other cycle → no writes; `done` = 1. Bytes are consumed only on cycles where `in_valid` and `in_ready` are both 1.
- Reset mid-frame: drop `reset` to 0 after the first payload byte → all outputs are at reset values immediately. A fresh `start` then reloads from address 0.
- Restart and ignored start: pulse `start` during DATA → no effect. After DONE, `start` plus a 1-byte frame (01, A0, FF, FF) → `done` clears then sets; write FF@0.

Source files
------------

// File: rtl/prog_loader.sv
// prog_loader: loads a framed byte stream (header, payload, checksum) into the
// nibble microprocessor's program memory and holds the CPU in reset while a
// load is in progress or after a failed load.
module prog_loader #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              prog_we,
    output logic [ADDR_W-1:0] prog_addr,
    output logic [DATA_W-1:0] prog_data,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_HDR_LO = 3'd1;
    localparam logic [2:0] S_HDR_HI = 3'd2;
    localparam logic [2:0] S_DATA   = 3'd3;
    localparam logic [2:0] S_CSUM   = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;
    localparam logic [2:0] S_ERR    = 3'd6;

    localparam logic [3:0] MAGIC = 4'hA;
    localparam int         LEN_HI_W = ADDR_W - DATA_W;

    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] len_q, len_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] sum_q, sum_d;
    logic              prog_we_q, prog_we_d;
    logic [ADDR_W-1:0] prog_addr_q, prog_addr_d;
    logic [DATA_W-1:0] prog_data_q, prog_data_d;

    logic              xfer;
    logic              idle_like;
    logic [ADDR_W-1:0] len_full;

    // Handshake and status decode straight from the state register.
    always_comb begin
        busy      = (state_q == S_HDR_LO) || (state_q == S_HDR_HI) ||
                    (state_q == S_DATA)   || (state_q == S_CSUM);
        in_ready  = busy;
        done      = (state_q == S_DONE);
        err       = (state_q == S_ERR);
        cpu_hold  = busy || err;
        idle_like = (state_q == S_IDLE) || done || err;
        xfer      = in_valid && in_ready;
        len_full  = {in_data[LEN_HI_W-1:0], len_q[DATA_W-1:0]};
    end

    // Next-state logic: frame parsing, payload write issue and checksum.
    // NOTE: every _d signal gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        sum_d       = sum_q;
        prog_we_d   = 1'b0;
        prog_addr_d = prog_addr_q;
        prog_data_d = prog_data_q;

        if (idle_like) begin
            if (start) begin
                state_d = S_HDR_LO;
                sum_d   = '0;
                cnt_d   = '0;
                addr_d  = '0;
            end
        end else if (xfer) begin
            case (state_q)
                S_HDR_LO: begin
                    len_d   = {{LEN_HI_W{1'b0}}, in_data};
                    state_d = S_HDR_HI;
                end
                S_HDR_HI: begin
                    if (in_data[DATA_W-1 -: 4] != MAGIC) begin
                        state_d = S_ERR;
                    end else begin
                        len_d   = len_full;
                        state_d = (len_full == '0) ? S_CSUM : S_DATA;
                    end
                end
                S_DATA: begin
                    prog_we_d   = 1'b1;
                    prog_addr_d = addr_q;
                    prog_data_d = in_data;
                    sum_d       = sum_q + in_data;
                    addr_d      = addr_q + ADDR_W'(1);
                    cnt_d       = cnt_q + ADDR_W'(1);
                    if (cnt_d == len_q) begin
                        state_d = S_CSUM;
                    end
                end
                S_CSUM: begin
                    state_d = (in_data == sum_q) ? S_DONE : S_ERR;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // State and registered write-port update; reset aborts any frame.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            len_q       <= '0;
            cnt_q       <= '0;
            addr_q      <= '0;
            sum_q       <= '0;
            prog_we_q   <= 1'b0;
            prog_addr_q <= '0;
            prog_data_q <= '0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            sum_q       <= sum_d;
            prog_we_q   <= prog_we_d;
            prog_addr_q <= prog_addr_d;
            prog_data_q <= prog_data_d;
        end
    end

    assign prog_we   = prog_we_q;
    assign prog_addr = prog_addr_q;
    assign prog_data = prog_data_q;

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: a table of frames applied in a loop,
// a write scoreboard (address, data, cycle), and a hand-written reset
// mid-frame sequence.
module tb_prog_loader;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        prog_we;
    logic [11:0] prog_addr;
    logic [7:0]  prog_data;
    logic        cpu_hold;
    logic        busy;
    logic        done;
    logic        err;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    prog_loader #(.ADDR_W(12), .DATA_W(8)) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .prog_we   (prog_we),
        .prog_addr (prog_addr),
        .prog_data (prog_data),
        .cpu_hold  (cpu_hold),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct packed {
        logic [11:0] addr;
        logic [7:0]  data;
        logic [31:0] cyc;
    } wr_t;

    wr_t         sb[$];
    logic [11:0] exp_addr;

    typedef struct {
        string           name;
        logic [0:7][7:0] b;
        int              n;
        int              plen;
        bit              stall;
        int              sidx;
        logic            exp_done;
        logic            exp_err;
        logic            exp_hold;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Write monitor: every prog_we pulse must match the oldest expected write.
    always @(negedge clock) begin
        if (prog_we === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got %0h@%0h expected none", prog_data, prog_addr);
            end else begin
                wr_t w;
                w = sb.pop_front();
                check("wr_addr", {20'd0, prog_addr}, {20'd0, w.addr});
                check("wr_data", {24'd0, prog_data}, {24'd0, w.data});
                check("wr_cycle", cyc, w.cyc);
            end
        end
    end

    // Offer one byte until accepted; payload bytes push an expected write.
    task automatic send(input logic [7:0] b, input bit payload, input bit stall, input bit strt);
        bit got;
        if (stall) begin
            in_valid = 1'b0;
            in_data  = 8'h5A;
            @(posedge clock); #1;
        end
        in_data  = b;
        in_valid = 1'b1;
        start    = strt;
        got      = 1'b0;
        for (int t = 0; t < 20 && !got; t++) begin
            got = in_ready;
            if (got && payload) begin
                sb.push_back('{addr: exp_addr, data: b, cyc: cyc + 1});
                exp_addr = exp_addr + 12'd1;
            end
            @(posedge clock); #1;
        end
        in_valid = 1'b0;
        start    = 1'b0;
        check("byte_accepted", {31'd0, got}, 32'd1);
    endtask

    task automatic pulse_start();
        exp_addr = 12'd0;
        start    = 1'b1;
        @(posedge clock); #1;
        start    = 1'b0;
        check("start_busy",  {31'd0, busy},     32'd1);
        check("start_hold",  {31'd0, cpu_hold}, 32'd1);
        check("start_ready", {31'd0, in_ready}, 32'd1);
        check("start_done",  {31'd0, done},     32'd0);
        check("start_err",   {31'd0, err},      32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"},  {31'd0, in_ready}, 32'd0);
        check({tag, "_prog_we"},   {31'd0, prog_we},  32'd0);
        check({tag, "_prog_addr"}, {20'd0, prog_addr}, 32'd0);
        check({tag, "_prog_data"}, {24'd0, prog_data}, 32'd0);
        check({tag, "_cpu_hold"},  {31'd0, cpu_hold}, 32'd0);
        check({tag, "_busy"},      {31'd0, busy},     32'd0);
        check({tag, "_done"},      {31'd0, done},     32'd0);
        check({tag, "_err"},       {31'd0, err},      32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0] = '{"good",      {8'h03, 8'hA0, 8'h12, 8'h34, 8'h56, 8'h9C, 16'h0000}, 6, 3, 1'b0, -1, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{"bad_csum",  {8'h03, 8'hA0, 8'h12, 8'h34, 8'h56, 8'h9D, 16'h0000}, 6, 3, 1'b0, -1, 1'b0, 1'b1, 1'b1};
        vecs[2] = '{"bad_magic", {8'h03, 8'h50, 48'h0},                                2, 0, 1'b0, -1, 1'b0, 1'b1, 1'b1};
        vecs[3] = '{"zero_len",  {8'h00, 8'hA0, 8'h00, 40'h0},                         3, 0, 1'b1, -1, 1'b1, 1'b0, 1'b0};
        vecs[4] = '{"wrap_sum",  {8'h02, 8'hA0, 8'hF0, 8'h20, 8'h10, 24'h0},           5, 2, 1'b0,  3, 1'b1, 1'b0, 1'b0};
        vecs[5] = '{"one_byte",  {8'h01, 8'hA0, 8'hFF, 8'hFF, 32'h0},                  4, 1, 1'b0, -1, 1'b1, 1'b0, 1'b0};

        reset    = 1'b0;
        start    = 1'b0;
        in_data  = 8'h00;
        in_valid = 1'b0;
        exp_addr = 12'd0;
        repeat (2) @(posedge clock);
        #1;
        check_reset_outputs("por");
        reset = 1'b1;
        @(posedge clock); #1;
        check("idle_ready", {31'd0, in_ready}, 32'd0);

        for (int i = 0; i < 6; i++) begin
            pulse_start();
            for (int j = 0; j < vecs[i].n; j++) begin
                send(vecs[i].b[j], (j >= 2) && (j < 2 + vecs[i].plen), vecs[i].stall, j == vecs[i].sidx);
            end
            check({vecs[i].name, "_done"},  {31'd0, done},     {31'd0, vecs[i].exp_done});
            check({vecs[i].name, "_err"},   {31'd0, err},      {31'd0, vecs[i].exp_err});
            check({vecs[i].name, "_hold"},  {31'd0, cpu_hold}, {31'd0, vecs[i].exp_hold});
            check({vecs[i].name, "_busy"},  {31'd0, busy},     32'd0);
            check({vecs[i].name, "_ready"}, {31'd0, in_ready}, 32'd0);
            if (vecs[i].exp_err) begin
                in_data  = 8'h12;
                in_valid = 1'b1;
                repeat (2) begin
                    @(posedge clock); #1;
                    check({vecs[i].name, "_err_ready"}, {31'd0, in_ready}, 32'd0);
                    check({vecs[i].name, "_err_stays"}, {31'd0, err},      32'd1);
                end
                in_valid = 1'b0;
            end
            repeat (2) @(posedge clock);
            #1;
            check({vecs[i].name, "_writes_drained"}, sb.size(), 32'd0);
        end

        // Reset mid-frame: after the first payload write, reset aborts to IDLE.
        pulse_start();
        send(8'h03, 1'b0, 1'b0, 1'b0);
        send(8'hA0, 1'b0, 1'b0, 1'b0);
        send(8'h12, 1'b1, 1'b0, 1'b0);
        @(negedge clock);
        #2;
        reset = 1'b0;
        #1;
        check_reset_outputs("midreset");
        check("midreset_sb", sb.size(), 32'd0);
        @(posedge clock); #1;
        reset = 1'b1;
        @(posedge clock); #1;
        pulse_start();
        send(8'h03, 1'b0, 1'b0, 1'b0);
        send(8'hA0, 1'b0, 1'b0, 1'b0);
        send(8'h12, 1'b1, 1'b0, 1'b0);
        send(8'h34, 1'b1, 1'b0, 1'b0);
        send(8'h56, 1'b1, 1'b0, 1'b0);
        send(8'h9C, 1'b0, 1'b0, 1'b0);
        check("reload_done", {31'd0, done},     32'd1);
        check("reload_hold", {31'd0, cpu_hold}, 32'd0);
        repeat (2) @(posedge clock);
        #1;
        check("reload_drained", sb.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
